// File: rtl/sdram_arbiter.sv
// Arbiter for the single-word SDRAM port: port 0 has strict priority, ports 1..NUM_REQ-1 share round-robin.
// Define SDRAM_ARB_STARVATION_GUARD_EN to let a waiting round-robin port win after STARVE_LIMIT back-to-back port-0 grants.
module sdram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 26,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*16-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [15:0]               req_rdata,
  output logic                      mem_request,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [15:0]               mem_wdata,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   rr_win;
  logic [IDX_W-1:0]   rr_after;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   idx_v;
  logic               rr_found;
  logic               force_rr;
  logic               grant_rr;
  logic               grant_any;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_address;
  logic [15:0]        sel_wdata;
  int                 idx;

  // Round-robin search over ports 1..NUM_REQ-1 starting at rr, wrapping back to 1.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    idx_v    = '0;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      idx = int'(rr) + off;
      if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
      idx_v = idx[IDX_W-1:0];
      if (!rr_found && req[idx_v]) begin
        rr_found = 1'b1;
        rr_win   = idx_v;
      end
    end
  end

`ifdef SDRAM_ARB_STARVATION_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_rr = rr_found && (starve_cnt == 4'(STARVE_LIMIT));

  // Counts port-0 grants that overtook a waiting round-robin request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant_any) begin
      if (grant_rr)      starve_cnt <= '0;
      else if (rr_found) starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign force_rr            = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  assign grant_rr  = rr_found && (!req[0] || force_rr);
  assign grant_any = req[0] || rr_found;
  assign win       = grant_rr ? rr_win : '0;
  assign rr_after  = (int'(rr_win) == NUM_REQ - 1) ? IDX_W'(1) : rr_win + 1'b1;

  always_comb begin
    sel_write   = 1'b0;
    sel_address = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_write   = req_write[i];
        sel_address = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata   = req_wdata[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  if (mem_ack)   state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured only in IDLE so requesters may change them freely while another access runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      req_ack     <= '0;
      req_rdata   <= '0;
      rr          <= IDX_W'(1);
      winner      <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_request <= 1'b1;
            mem_write   <= sel_write;
            mem_address <= sel_address;
            mem_wdata   <= sel_wdata;
            winner      <= win;
            if (grant_rr) rr <= rr_after;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_request     <= 1'b0;
            req_rdata       <= mem_rdata;
            req_ack[winner] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed scenarios plus a randomized phase with a queue-based scoreboard.
// Expectations adapt when SDRAM_ARB_STARVATION_GUARD_EN is defined.
module tb_sdram_arbiter;

  localparam int N     = 3;
  localparam int AW    = 26;
  localparam int LIMIT = 4;
`ifdef SDRAM_ARB_STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_address;
  logic [N*16-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [15:0]     req_rdata;
  logic            mem_request, mem_write;
  logic [AW-1:0]   mem_address;
  logic [15:0]     mem_wdata;
  logic            mem_ack;
  logic [15:0]     mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {int port; logic [15:0] rdata;} resp_t;
  resp_t exp_q[$];

  logic [N-1:0]    req_s, wr_s;
  logic [N*AW-1:0] addr_s;
  logic [N*16-1:0] wd_s;
  bit              auto_en = 1'b0;
  bit              stop    = 1'b0;
  bit              busy    = 1'b0;
  int              lat_left, cur_port;
  logic            cap_w;
  logic [AW-1:0]   cap_a;
  logic [15:0]     cap_d;
  int              model_rr  = 1;
  int              model_cnt = 0;

  sdram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_rdata(req_rdata), .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_s  <= req;
    wr_s   <= req_write;
    addr_s <= req_address;
    wd_s   <= req_wdata;
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int p, input logic r, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    req[p]                 = r;
    req_write[p]           = w;
    req_address[p*AW +: AW] = a;
    req_wdata[p*16 +: 16]   = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; req_write = '0; req_address = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    model_rr  = 1;
    model_cnt = 0;
    @(negedge clk);
  endtask

  // Priority first; otherwise the waiting port closest after the pointer in the ring 1..N-1.
  task automatic model_grant(input logic [N-1:0] r, output int w);
    int best  = -1;
    int bestd = N;
    int d;
    for (int k = 1; k < N; k++) begin
      if (r[k]) begin
        d = (k - model_rr + (N - 1)) % (N - 1);
        if (d < bestd) begin bestd = d; best = k; end
      end
    end
    if (r[0] && !(GUARD && best >= 0 && model_cnt == LIMIT)) begin
      w = 0;
      if (best >= 0) model_cnt++;
    end else if (best >= 0) begin
      w = best;
      model_rr  = best % (N - 1) + 1;
      model_cnt = 0;
    end else begin
      w = -1;
    end
  endtask

  // Waits for a grant, acks it after lat cycles, and checks the completion pulse.
  task automatic serve_one(input logic [15:0] rdata, input int lat, output int port,
                           output logic w, output logic [AW-1:0] a, output logic [15:0] d);
    int waited = 0;
    port = -1;
    while (!mem_request && waited < 50) begin @(negedge clk); waited++; end
    check_output("serve_grant_seen", mem_request, 1'b1);
    w = mem_write; a = mem_address; d = mem_wdata;
    for (int p = 0; p < N; p++)
      if (mem_address == req_address[p*AW +: AW]) port = p;
    repeat (lat) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("serve_req_ack", req_ack, (port >= 0) ? 64'(1 << port) : 64'(0));
    check_output("serve_rdata", req_rdata, rdata);
  endtask

  // Randomized requesters and SDRAM model; each grant is predicted and its response queued.
  always @(negedge clk) begin
    int wexp;
    if (auto_en) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
        check_output("rand_request_dropped", mem_request, 1'b0);
      end else begin
        if (!busy && mem_request) begin
          model_grant(req_s, wexp);
          cur_port = wexp;
          if (wexp < 0) begin
            check_output("rand_spurious_grant", mem_request, 1'b0);
          end else begin
            cap_w = wr_s[wexp];
            cap_a = addr_s[wexp*AW +: AW];
            cap_d = wd_s[wexp*16 +: 16];
          end
          busy     = 1'b1;
          lat_left = $urandom_range(0, 4);
        end
        if (busy) begin
          check_output("rand_hold_request", mem_request, 1'b1);
          if (cur_port >= 0) begin
            check_output("rand_hold_write", mem_write, cap_w);
            check_output("rand_hold_address", mem_address, cap_a);
            check_output("rand_hold_wdata", mem_wdata, cap_d);
          end
          if (lat_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'($urandom);
            exp_q.push_back('{port: cur_port, rdata: mem_rdata});
          end else begin
            lat_left--;
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        if (req[p] && req_ack[p]) begin
          if (!stop && $urandom_range(0, 1) == 1)
            apply_stimulus(p, 1'b1, 1'($urandom), {3'(p), 23'($urandom)}, 16'($urandom));
          else
            req[p] = 1'b0;
        end else if (!req[p]) begin
          if (!stop && $urandom_range(0, (p == 0) ? 5 : 2) == 0)
            apply_stimulus(p, 1'b1, 1'($urandom), {3'(p), 23'($urandom)}, 16'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          apply_stimulus(p, 1'b1, 1'($urandom), {3'(p), 23'($urandom)}, 16'($urandom));
        end
      end
    end
  end

  // Scoreboard monitor: every completion pulse must match the oldest queued response.
  always @(negedge clk) begin
    resp_t e;
    if (auto_en && req_ack != '0) begin
      if (exp_q.size() == 0) begin
        check_output("rand_unexpected_ack", req_ack, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("rand_ack_port", req_ack, (e.port >= 0) ? 64'(1 << e.port) : 64'(0));
        check_output("rand_ack_rdata", req_rdata, e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p, waited;
    logic w;
    logic [AW-1:0] a;
    logic [15:0] d;
`ifdef SDRAM_ARB_STARVATION_GUARD_EN
    int exp_a[6]  = '{0, 0, 0, 0, 1, 0};
    int exp_b[4]  = '{2, 1, 2, 1};
    int exp_g[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
`else
    int exp_a[6]  = '{0, 0, 0, 0, 0, 0};
    int exp_b[4]  = '{1, 2, 1, 2};
    int exp_g[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    reset_n = 1'b0;
    req = '0; req_write = '0; req_address = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check_output("reset_mem_request", mem_request, 1'b0);
    check_output("reset_mem_write", mem_write, 1'b0);
    check_output("reset_mem_address", mem_address, 0);
    check_output("reset_mem_wdata", mem_wdata, 0);
    check_output("reset_req_ack", req_ack, 0);
    check_output("reset_req_rdata", req_rdata, 0);

    // Single read on port 1 with mem_ack at T+3.
    apply_reset();
    apply_stimulus(1, 1'b1, 1'b0, 26'h0001234, 16'h0000);
    #1 check_output("read_no_comb_path", mem_request, 1'b0);
    @(negedge clk);
    check_output("read_req_t1", mem_request, 1'b1);
    check_output("read_addr", mem_address, 26'h0001234);
    check_output("read_write_flag", mem_write, 1'b0);
    @(negedge clk);
    check_output("read_req_t2", mem_request, 1'b1);
    @(negedge clk);
    check_output("read_req_t3", mem_request, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("read_ack_t4", req_ack, 3'b010);
    check_output("read_rdata", req_rdata, 16'hBEEF);
    check_output("read_req_low_t4", mem_request, 1'b0);
    req[1] = 1'b0;
    @(negedge clk);
    check_output("read_ack_one_cycle", req_ack, 0);

    // All three ports requesting, then port 0 drops out.
    apply_reset();
    apply_stimulus(0, 1'b1, 1'b0, 26'h0000100, 16'h0);
    apply_stimulus(1, 1'b1, 1'b0, 26'h0000200, 16'h0);
    apply_stimulus(2, 1'b1, 1'b0, 26'h0000300, 16'h0);
    for (int g = 0; g < 6; g++) begin
      serve_one(16'h1000 + 16'(g), 0, p, w, a, d);
      check_output("prio_grant", p, exp_a[g]);
    end
    req[0] = 1'b0;
    for (int g = 0; g < 4; g++) begin
      serve_one(16'h2000 + 16'(g), 1, p, w, a, d);
      check_output("rr_grant", p, exp_b[g]);
    end
    req = '0;

    // Ports 0 and 2 requesting continuously.
    apply_reset();
    apply_stimulus(0, 1'b1, 1'b0, 26'h0000100, 16'h0);
    apply_stimulus(2, 1'b1, 1'b0, 26'h0000300, 16'h0);
    for (int g = 0; g < 10; g++) begin
      serve_one(16'h3000 + 16'(g), 0, p, w, a, d);
      check_output("starve_grant", p, exp_g[g]);
    end
    req = '0;

    // Port 2 write at the top address while port 1 changes its operands.
    apply_reset();
    apply_stimulus(2, 1'b1, 1'b1, 26'h3FFFFFF, 16'h5A5A);
    @(negedge clk);
    apply_stimulus(1, 1'b1, 1'b0, 26'h0000111, 16'h1111);
    for (int c = 0; c < 3; c++) begin
      check_output("hold_request", mem_request, 1'b1);
      check_output("hold_write", mem_write, 1'b1);
      check_output("hold_address", mem_address, 26'h3FFFFFF);
      check_output("hold_wdata", mem_wdata, 16'h5A5A);
      if (c == 1) apply_stimulus(1, 1'b1, 1'b1, 26'h0ABCDEF, 16'hC3C3);
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 16'h0F0F; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check_output("hold_ack_port2", req_ack, 3'b100);
    req[2] = 1'b0;
    serve_one(16'h7777, 1, p, w, a, d);
    check_output("latest_ops_port", p, 1);
    check_output("latest_ops_write", w, 1'b1);
    check_output("latest_ops_address", a, 26'h0ABCDEF);
    check_output("latest_ops_wdata", d, 16'hC3C3);
    req = '0;

    // Reset during ACCESS, after rr has moved past port 1.
    apply_reset();
    apply_stimulus(1, 1'b1, 1'b0, 26'h0000010, 16'h0);
    serve_one(16'hA5A5, 0, p, w, a, d);
    req[1] = 1'b0;
    apply_stimulus(2, 1'b1, 1'b0, 26'h0000020, 16'h0);
    waited = 0;
    @(negedge clk);
    while (!mem_request && waited < 10) begin @(negedge clk); waited++; end
    check_output("rst_access_entered", mem_request, 1'b1);
    req[1] = 1'b1;
    reset_n = 1'b0;
    #1;
    check_output("rst_mem_request", mem_request, 1'b0);
    check_output("rst_req_ack", req_ack, 0);
    check_output("rst_req_rdata", req_rdata, 0);
    check_output("rst_mem_address", mem_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    serve_one(16'h4242, 0, p, w, a, d);
    check_output("rst_first_grant", p, 1);
    req = '0;

    // Stray mem_ack pulses with nothing requested.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'($urandom);
      @(negedge clk);
      mem_ack = 1'b0;
      check_output("stray_req_ack", req_ack, 0);
      check_output("stray_rdata", req_rdata, 16'h4242);
      check_output("stray_mem_request", mem_request, 1'b0);
    end

    // Randomized traffic against the reference model.
    apply_reset();
    busy = 1'b0; stop = 1'b0; exp_q.delete();
    auto_en = 1'b1;
    repeat (3000) @(negedge clk);
    stop = 1'b1;
    waited = 0;
    while ((req != '0 || busy || exp_q.size() != 0) && waited < 1000) begin
      @(negedge clk); waited++;
    end
    repeat (3) @(negedge clk);
    auto_en = 1'b0;
    check_output("drain_requests", req, 0);
    check_output("drain_scoreboard_empty", exp_q.size(), 0);
    check_output("drain_mem_request", mem_request, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

- Shares the single SDRAM memory port between `NUM_REQ` requesters.
- Requester 0 is the N64 SDRAM path (`ID_N64_SDRAM` traffic) and has strict priority; requesters 1..`NUM_REQ`-1 (CPU, USB/flashram DMA) share by round-robin.
- The block sits between the requester-side bus adapters and the SDRAM controller.
- Each access is a single 16-bit word under a req/ack handshake.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8); index 0 is the priority port.
- `ADDR_W`, 26, word address width on all ports.
- `STARVE_LIMIT`, 4, consecutive port-0 grants allowed while another request waits (used only with the guard enabled).
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-port request level.
- `req_write`  in  NUM_REQ  per-port write flag, 1 = write.
- `req_address`  in  NUM_REQ*ADDR_W  packed addresses; port i is at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*16  packed write data.
- `req_ack`  out  NUM_REQ  one-cycle completion pulse per port.
- `req_rdata`  out  16  read data, valid while any `req_ack` bit is high.
- `mem_request`  out  1  access request to the SDRAM controller.
- `mem_write`  out  1  write flag.
- `mem_address`  out  ADDR_W  address.
- `mem_wdata`  out  16  write data.
- `mem_ack`  in  1  one-cycle completion from the SDRAM controller.
- `mem_rdata`  in  16  read data, valid with `mem_ack`.

## Operation
- FSM has three states:
  - IDLE: sample `req` and pick a winner. If there is a winner, latch its write flag, address and wdata into `mem_*` and go to ACCESS.
  - ACCESS: hold `mem_request`=1 and all `mem_*` stable until `mem_ack`=1. On `mem_ack`, latch `mem_rdata` into `req_rdata`, drop `mem_request`, go to RESPOND.
  - RESPOND: `req_ack[winner]`=1 for exactly this cycle, then go to IDLE.
- Winner selection:
  - If `req[0]`=1, port 0 wins.
  - Otherwise the round-robin search starts at pointer `rr`, covers ports 1..NUM_REQ-1, and wraps from NUM_REQ-1 to 1.
  - After a round-robin grant to port k, `rr` becomes k+1, wrapping to 1.
  - A port-0 grant leaves `rr` unchanged.
- Requester rules:
  - Hold `req` and all operands stable from assertion until its `req_ack`.
  - Deassert `req` at the edge ending the ack cycle, or keep it high to issue a back-to-back access.
  - The arbiter never reads operands outside IDLE, so changes during ACCESS/RESPOND are ignored.
- Requests arriving during ACCESS or RESPOND wait; no request is lost or reordered within a port.
- Reset (`reset_n`=0, asynchronous, any state) sets:
  - state IDLE, `mem_request`=0, `mem_write`=0;
  - `mem_address`=0, `mem_wdata`=0;
  - `req_ack`=0, `req_rdata`=0;
  - `rr`=1, starvation counter=0.
- An access in flight at reset is abandoned. The SDRAM controller shares the same reset.
- `mem_ack` outside ACCESS is ignored.

## Timing
- `req` high in IDLE cycle T:
  - `mem_request`=1 from T+1.
  - `mem_ack` arrives at cycle A ≥ T+1.
  - `req_ack`=1 at A+1.
  - Next arbitration happens at A+2.
- Minimum turnaround with an immediate `mem_ack` is 3 cycles per access.
- All outputs are registered; there is no combinational path from `req` or `mem_ack` to any output.

## Configuration
- `SDRAM_ARB_STARVATION_GUARD_EN` defined:
  - A 4-bit counter increments on each port-0 grant made while any `req[NUM_REQ-1:1]` is high.
  - When the counter equals `STARVE_LIMIT`, the next IDLE arbitration uses the round-robin winner even if `req[0]`=1, and the counter clears.
  - The counter also clears on any round-robin grant.
- Not defined: port 0 has strict priority always, no counter is implemented, and `STARVE_LIMIT` is unused.

## Test plan
- Single read, port 1, address 0x0001234, `mem_ack` at T+3 with rdata 0xBEEF:
  - `mem_request` high T+1..T+3;
  - `req_ack`=3'b010 at T+4;
  - `req_rdata`=0xBEEF.
- Ports 0, 1, 2 all request continuously for 6 grants, guard disabled:
  - Every grant goes to port 0.
  - Drop `req[0]`: grants alternate 1, 2, 1, 2.
- Guard enabled, `STARVE_LIMIT`=4, ports 0 and 2 requesting continuously:
  - Grant sequence is 0, 0, 0, 0, 2, 0, 0, 0, 0, 2.
- Port 2 write 0x5A5A to 0x3FFFFFF (`ADDR_W` max), port 1 changes its operands during port 2's ACCESS:
  - `mem_*` stay 1 / 0x3FFFFFF / 0x5A5A until `mem_ack`;
  - port 1 is served next with its latest operands.
- Assert `reset_n`=0 during ACCESS:
  - `mem_request`, `req_ack` and `req_rdata` are 0 immediately.
  - After release, the first grant from ports 1 and 2 goes to port 1 (`rr`=1).
- Stray `mem_ack` pulses in IDLE with no requests:
  - no `req_ack`;
  - `req_rdata` is unchanged.
